fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the program-counter datapath. Each cycle it decides whether the PC register advances, holds, follows a BTB prediction or takes an EX-stage redirect. It drives the instruction-memory request handshake, including variable-latency fetches, and generates the IF/ID and ID/EX stall and flush controls. It also keeps two saturating performance counters.

---
 rtl/fetch_ctrl_pkg.sv | 8 +
 rtl/sat_cnt.sv | 18 +
 rtl/fetch_ctrl.sv | 116 +++++++++++
 tb/tb_fetch_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: fetch sequencer state encoding and PC source selector values
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALT_DRAIN, HALT} state_e;
  localparam logic [1:0] PC_SEL_SEQ   = 2'd0;
  localparam logic [1:0] PC_SEL_BTB   = 2'd1;
  localparam logic [1:0] PC_SEL_REDIR = 2'd2;
  localparam logic [1:0] PC_SEL_PEND  = 2'd3;
endpackage

// File: rtl/sat_cnt.sv
// sat_cnt: saturating event counter with synchronous clear taking priority
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  // count up until all-ones, clear wins over increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (inc && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign cnt = cnt_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage PC sequencer, imem handshake, pipeline stall/flush and perf counters
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic             hz_stall,
  input  logic             hlt_id,
  input  logic             redirect_ex,
  input  logic [15:0]      redirect_pc_ex,
  input  logic             btb_hit_if,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [15:0]      pend_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] imem_wait_cnt
);
  state_e      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  // Mealy control: an outstanding fetch is never abandoned, so redirects and halts wait in DRAIN/HALT_DRAIN
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    imem_req    = 1'b1;
    pc_we       = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    unique case (state_q)
      RUN:
        if (redirect_ex) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          if (imem_ack) begin
            pc_we  = 1'b1;
            pc_sel = PC_SEL_REDIR;
          end else begin
            pend_d  = redirect_pc_ex;
            state_d = DRAIN;
          end
        end else if (hlt_id && !hz_stall) begin
          flush_if_id = 1'b1;
          state_d     = imem_ack ? HALT : HALT_DRAIN;
        end else if (hz_stall) begin
          stall_if_id = 1'b1;
        end else if (imem_ack) begin
          pc_we  = 1'b1;
          pc_sel = btb_hit_if ? PC_SEL_BTB : PC_SEL_SEQ;
        end else begin
          flush_if_id = 1'b1;
        end
      DRAIN: begin
        flush_if_id = 1'b1;
        if (redirect_ex) pend_d = redirect_pc_ex;
        else if (imem_ack) begin
          pc_we   = 1'b1;
          pc_sel  = PC_SEL_PEND;
          state_d = RUN;
        end
      end
      HALT_DRAIN: begin
        flush_if_id = 1'b1;
        if (redirect_ex) begin
          pend_d  = redirect_pc_ex;
          state_d = DRAIN;
        end else if (imem_ack) state_d = HALT;
      end
      HALT: begin
        imem_req    = 1'b0;
        flush_if_id = 1'b1;
        if (redirect_ex) begin
          pc_we       = 1'b1;
          pc_sel      = PC_SEL_REDIR;
          flush_id_ex = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end
  // state and latched redirect target
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  assign pend_pc = pend_q;
  assign halted  = (state_q == HALT);
  sat_cnt #(.W(CNT_W)) u_redirect_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_cnt),
    .inc  (redirect_ex),
    .cnt  (redirect_cnt)
  );
  sat_cnt #(.W(CNT_W)) u_imem_wait_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_cnt),
    .inc  (imem_req && !imem_ack),
    .cnt  (imem_wait_cnt)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized run against a transaction-level fetch model
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, hz_stall, hlt_id, redirect_ex, btb_hit_if;
  logic [15:0] redirect_pc_ex;
  logic        pc_we, stall_if_id, flush_if_id, flush_id_ex, halted, clr_cnt;
  logic [1:0]  pc_sel;
  logic [15:0] pend_pc, redirect_cnt, imem_wait_cnt;
  int n_checks = 0;
  int n_errors = 0;

  fetch_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
    .hz_stall(hz_stall), .hlt_id(hlt_id), .redirect_ex(redirect_ex),
    .redirect_pc_ex(redirect_pc_ex), .btb_hit_if(btb_hit_if), .pc_we(pc_we),
    .pc_sel(pc_sel), .pend_pc(pend_pc), .stall_if_id(stall_if_id),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .halted(halted),
    .clr_cnt(clr_cnt), .redirect_cnt(redirect_cnt), .imem_wait_cnt(imem_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rd, input logic [15:0] rpc, input logic hl,
                       input logic hz, input logic ak, input logic bt, input logic cl);
    redirect_ex = rd; redirect_pc_ex = rpc; hlt_id = hl; hz_stall = hz;
    imem_ack = ak; btb_hit_if = bt; clr_cnt = cl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(0, 16'h0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({imem_req, flush_if_id, pc_we, pc_sel, stall_if_id, flush_id_ex, halted} !== 8'b1100_0000 ||
        pend_pc !== 16'h0 || redirect_cnt !== 16'h0 || imem_wait_cnt !== 16'h0) begin
      n_errors++;
      $display("FAIL reset: req=%b fif=%b we=%b sel=%0d st=%b fidex=%b halted=%b pend=%h rc=%0d wc=%0d, want req=1 fif=1 others 0",
               imem_req, flush_if_id, pc_we, pc_sel, stall_if_id, flush_id_ex, halted, pend_pc, redirect_cnt, imem_wait_cnt);
    end
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || flush_if_id !== 1'b1 || pc_we !== 1'b0 || halted !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: req=%b fif=%b we=%b halted=%b, want 1 1 0 0", imem_req, flush_if_id, pc_we, halted);
    end
  endtask

  task automatic test_zero_wait;
    drive(0, 16'h0, 0, 0, 1, 0, 1);
    tick();
    drive(0, 16'h0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (pc_we !== 1'b1 || pc_sel !== 2'd0 || flush_if_id !== 1'b0 || imem_wait_cnt !== 16'h0) begin
        n_errors++;
        $display("FAIL zero_wait[%0d]: we=%b sel=%0d fif=%b wc=%0d, want 1 0 0 0", i, pc_we, pc_sel, flush_if_id, imem_wait_cnt);
      end
      tick();
    end
  endtask

  task automatic test_btb;
    drive(0, 16'h0, 0, 0, 1, 1, 0);
    @(negedge clk);
    n_checks++;
    if (pc_we !== 1'b1 || pc_sel !== 2'd1) begin
      n_errors++;
      $display("FAIL btb_hit: we=%b sel=%0d, want 1 1", pc_we, pc_sel);
    end
    tick();
  endtask

  task automatic test_late_redirect;
    drive(0, 16'h0, 0, 0, 1, 0, 1);
    tick();
    drive(1, 16'h0040, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1 || pc_we !== 1'b0) begin
      n_errors++;
      $display("FAIL redir_issue: fif=%b fidex=%b we=%b, want 1 1 0", flush_if_id, flush_id_ex, pc_we);
    end
    tick();
    drive(0, 16'h0, 0, 0, 0, 0, 0);
    n_checks++;
    if (pend_pc !== 16'h0040) begin
      n_errors++;
      $display("FAIL redir_pend: pend_pc=%h, want 0040", pend_pc);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (flush_if_id !== 1'b1 || pc_we !== 1'b0 || imem_req !== 1'b1 || flush_id_ex !== 1'b0) begin
        n_errors++;
        $display("FAIL redir_drain[%0d]: fif=%b we=%b req=%b fidex=%b, want 1 0 1 0", i, flush_if_id, pc_we, imem_req, flush_id_ex);
      end
      tick();
    end
    drive(0, 16'h0, 0, 0, 1, 0, 0);
    @(negedge clk);
    n_checks++;
    if (flush_if_id !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 2'd3) begin
      n_errors++;
      $display("FAIL redir_ack: fif=%b we=%b sel=%0d, want 1 1 3", flush_if_id, pc_we, pc_sel);
    end
    tick();
    n_checks++;
    if (redirect_cnt !== 16'd1 || imem_wait_cnt !== 16'd3) begin
      n_errors++;
      $display("FAIL redir_counts: rc=%0d wc=%0d, want 1 3", redirect_cnt, imem_wait_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (pc_we !== 1'b1 || pc_sel !== 2'd0 || flush_if_id !== 1'b0) begin
      n_errors++;
      $display("FAIL redir_back_run: we=%b sel=%0d fif=%b, want 1 0 0", pc_we, pc_sel, flush_if_id);
    end
    tick();
  endtask

  task automatic test_hz_stall;
    drive(0, 16'h0, 0, 1, 1, 1, 0);
    @(negedge clk);
    n_checks++;
    if (pc_we !== 1'b0 || stall_if_id !== 1'b1 || imem_req !== 1'b1 || flush_if_id !== 1'b0) begin
      n_errors++;
      $display("FAIL hz_stall: we=%b stall=%b req=%b fif=%b, want 0 1 1 0", pc_we, stall_if_id, imem_req, flush_if_id);
    end
    tick();
  endtask

  task automatic test_halt;
    drive(0, 16'h0, 1, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (flush_if_id !== 1'b1 || pc_we !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_issue: fif=%b we=%b, want 1 0", flush_if_id, pc_we);
    end
    tick();
    drive(0, 16'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || halted !== 1'b0 || flush_if_id !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_drain: req=%b halted=%b fif=%b, want 1 0 1", imem_req, halted, flush_if_id);
    end
    tick();
    drive(0, 16'h0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 16'h0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || flush_if_id !== 1'b1 || pc_we !== 1'b0) begin
        n_errors++;
        $display("FAIL halted[%0d]: req=%b halted=%b fif=%b we=%b, want 0 1 1 0", i, imem_req, halted, flush_if_id, pc_we);
      end
      tick();
    end
    drive(1, 16'h0010, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (pc_we !== 1'b1 || pc_sel !== 2'd2 || flush_id_ex !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_redirect: we=%b sel=%0d fidex=%b, want 1 2 1", pc_we, pc_sel, flush_id_ex);
    end
    tick();
    drive(0, 16'h0, 0, 0, 1, 0, 0);
    @(negedge clk);
    n_checks++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 2'd0 || pend_pc !== 16'h0040) begin
      n_errors++;
      $display("FAIL halt_resume: halted=%b req=%b we=%b sel=%0d pend=%h, want 0 1 1 0 0040", halted, imem_req, pc_we, pc_sel, pend_pc);
    end
    tick();
  endtask

  task automatic test_saturation;
    drive(0, 16'h0, 0, 0, 1, 0, 1);
    tick();
    drive(0, 16'h0, 0, 0, 0, 0, 0);
    repeat (65536 + 5) @(posedge clk);
    #1;
    n_checks++;
    if (imem_wait_cnt !== 16'hFFFF) begin
      n_errors++;
      $display("FAIL wait_saturate: wc=%h, want ffff", imem_wait_cnt);
    end
    drive(0, 16'h0, 0, 0, 0, 0, 1);
    tick();
    n_checks++;
    if (imem_wait_cnt !== 16'h0 || redirect_cnt !== 16'h0) begin
      n_errors++;
      $display("FAIL clr_cnt: wc=%h rc=%h, want 0 0", imem_wait_cnt, redirect_cnt);
    end
  endtask

  task automatic test_random;
    bit        m_halted = 0;
    bit        m_fetch_busy = 0;
    bit        m_to_halt = 0;
    bit [15:0] m_pend = 16'h0040;
    int        m_rc = 0, m_wc = 0;
    bit rd, hl, hz, ak, bt, cl;
    bit [15:0] rpc;
    bit e_req, e_we, e_st, e_fif, e_fid;
    bit [1:0] e_sel;
    drive(0, 16'h0, 0, 0, 1, 0, 1);
    tick();
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(15) == 0); hl = ($urandom_range(11) == 0);
      hz = ($urandom_range(3) == 0); ak = $urandom_range(1); bt = $urandom_range(1);
      cl = ($urandom_range(63) == 0); rpc = 16'($urandom);
      drive(rd, rpc, hl, hz, ak, bt, cl);
      e_req = !m_halted; e_we = 0; e_sel = 0; e_st = 0; e_fif = 0; e_fid = 0;
      if (m_halted) begin
        e_fif = 1;
        if (rd) begin e_we = 1; e_sel = 2; e_fid = 1; end
      end else if (m_fetch_busy) begin
        e_fif = 1;
        if (!rd && ak && !m_to_halt) begin e_we = 1; e_sel = 3; end
      end else if (rd) begin
        e_fif = 1; e_fid = 1;
        if (ak) begin e_we = 1; e_sel = 2; end
      end else if (hl && !hz) e_fif = 1;
      else if (hz) e_st = 1;
      else if (ak) begin e_we = 1; e_sel = bt ? 2'd1 : 2'd0; end
      else e_fif = 1;
      @(negedge clk);
      n_checks++;
      if ({imem_req, pc_we, pc_sel, stall_if_id, flush_if_id, flush_id_ex, halted, pend_pc, redirect_cnt, imem_wait_cnt} !==
          {e_req, e_we, e_sel, e_st, e_fif, e_fid, m_halted, m_pend, 16'(m_rc), 16'(m_wc)}) begin
        n_errors++;
        $display("FAIL random[%0d]: got req=%b we=%b sel=%0d st=%b fif=%b fidex=%b halted=%b pend=%h rc=%0d wc=%0d, want %b %b %0d %b %b %b %b %h %0d %0d",
                 i, imem_req, pc_we, pc_sel, stall_if_id, flush_if_id, flush_id_ex, halted, pend_pc, redirect_cnt, imem_wait_cnt,
                 e_req, e_we, e_sel, e_st, e_fif, e_fid, m_halted, m_pend, m_rc, m_wc);
      end
      m_rc = cl ? 0 : (rd && m_rc < 65535) ? m_rc + 1 : m_rc;
      m_wc = cl ? 0 : (e_req && !ak && m_wc < 65535) ? m_wc + 1 : m_wc;
      if (m_halted) m_halted = !rd;
      else if (m_fetch_busy) begin
        if (rd) begin m_pend = rpc; m_to_halt = 0; end
        else if (ak) begin m_fetch_busy = 0; m_halted = m_to_halt; m_to_halt = 0; end
      end else if (rd) begin
        if (!ak) begin m_pend = rpc; m_fetch_busy = 1; m_to_halt = 0; end
      end else if (hl && !hz) begin
        if (ak) m_halted = 1;
        else begin m_fetch_busy = 1; m_to_halt = 1; end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_zero_wait();
    test_btb();
    test_late_redirect();
    test_hz_stall();
    test_halt();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
